// File: rtl/fx3_bus_out_path.sv
// fx3_bus_out_path: drains one packet from an FWFT buffer onto the FX3 slave-FIFO write port.
// Revision 1.0
`default_nettype none

module fx3_bus_out_path #(
  parameter int DATA_WIDTH        = 32,
  parameter int FULL_PACKET_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_out_path_enable,
  output logic                  o_out_path_busy,
  output logic                  o_out_path_finished,
  input  logic [23:0]           i_packet_size,
  input  logic                  i_dma_ready,
  input  logic                  i_buf_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_data_read,
  output logic                  o_write_enable,
  output logic                  o_packet_end,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [23:0]           o_write_count
);

  // FULL_PACKET_WORDS must be a power of two, at least 2.
  localparam int OFF_W = $clog2(FULL_PACKET_WORDS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DMA = 3'd1,
    WRITE    = 3'd2,
    ZLP      = 3'd3,
    FLUSH    = 3'd4,
    FINISHED = 3'd5
  } state_t;

  state_t      state;
  logic [23:0] size_reg;
  logic        pop;
  logic        last_pop;
  logic        short_pkt;

  assign pop       = (state == WRITE) && i_dma_ready && i_buf_ready;
  assign last_pop  = pop && (o_write_count == (size_reg - 24'd1));
  // Packets that do not fill a whole DMA buffer need PKTEND to commit them.
  assign short_pkt = |size_reg[OFF_W-1:0];

  assign o_data_read         = pop;
  assign o_out_path_busy     = (state != IDLE) && (state != FINISHED);
  assign o_out_path_finished = (state == FINISHED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      size_reg       <= 24'd0;
      o_write_count  <= 24'd0;
      o_write_enable <= 1'b0;
      o_packet_end   <= 1'b0;
      o_data         <= '0;
    end else begin
      o_write_enable <= 1'b0;
      o_packet_end   <= 1'b0;
      case (state)
        IDLE: begin
          o_write_count <= 24'd0;
          if (i_out_path_enable) begin
            size_reg <= i_packet_size;
            if (!i_dma_ready)
              state <= WAIT_DMA;
            else if (i_packet_size != 24'd0)
              state <= WRITE;
            else
              state <= ZLP;
          end
        end
        WAIT_DMA: begin
          if (i_dma_ready)
            state <= (size_reg != 24'd0) ? WRITE : ZLP;
        end
        WRITE: begin
          if (pop) begin
            o_data         <= i_data;
            o_write_enable <= 1'b1;
            o_write_count  <= o_write_count + 24'd1;
            if (last_pop) begin
              o_packet_end <= short_pkt;
              state        <= FLUSH;
            end
          end
        end
        ZLP: begin
          o_packet_end <= 1'b1;
          state        <= FLUSH;
        end
        FLUSH: begin
          state <= FINISHED;
        end
        FINISHED: begin
          if (!i_out_path_enable)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fx3_bus_out_path.sv
// tb_fx3_bus_out_path: scoreboard bench for the FX3 write path.
`timescale 1ns/1ps
`default_nettype none

module tb_fx3_bus_out_path;

  localparam int DW = 32;
  localparam int M_NORMAL  = 0;
  localparam int M_DMAGAP  = 1;
  localparam int M_TOGGLE  = 2;
  localparam int M_DROP    = 3;
  localparam int M_WAITDMA = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_out_path_enable;
  logic          o_out_path_busy;
  logic          o_out_path_finished;
  logic [23:0]   i_packet_size;
  logic          i_dma_ready;
  logic          i_buf_ready;
  logic [DW-1:0] i_data;
  logic          o_data_read;
  logic          o_write_enable;
  logic          o_packet_end;
  logic [DW-1:0] o_data;
  logic [23:0]   o_write_count;

  always #5 clk = ~clk;

  fx3_bus_out_path #(.DATA_WIDTH(DW), .FULL_PACKET_WORDS(256)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_out_path_enable   (i_out_path_enable),
    .o_out_path_busy     (o_out_path_busy),
    .o_out_path_finished (o_out_path_finished),
    .i_packet_size       (i_packet_size),
    .i_dma_ready         (i_dma_ready),
    .i_buf_ready         (i_buf_ready),
    .i_data              (i_data),
    .o_data_read         (o_data_read),
    .o_write_enable      (o_write_enable),
    .o_packet_end        (o_packet_end),
    .o_data              (o_data),
    .o_write_count       (o_write_count)
  );

  typedef struct packed {
    logic          zlp;
    logic          pe;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] buf_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          buf_gate = 1'b1;
  int            buf_cnt = 0;
  logic [DW-1:0] head = '0;
  logic          popped = 1'b0;
  int            pop_total = 0;
  int            we_total = 0;
  int            pe_total = 0;

  assign i_buf_ready = buf_gate && (buf_cnt != 0);
  assign i_data      = head;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FWFT model: the DUT's pop is seen at the edge, the head advances at the next negedge.
  always @(posedge clk) begin
    popped <= o_data_read && !rst;
    if (o_data_read && !rst) pop_total <= pop_total + 1;
  end

  always @(negedge clk) begin
    if (popped && buf_q.size() > 0) void'(buf_q.pop_front());
    buf_cnt = buf_q.size();
    head    = (buf_q.size() > 0) ? buf_q[0] : '0;
  end

  // Bus monitor: every strobe on the FX3 side must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (o_write_enable || o_packet_end)) begin
      if (o_write_enable) we_total++;
      if (o_packet_end) pe_total++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {o_write_enable, o_packet_end}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("write_enable", o_write_enable, !e.zlp);
        check("packet_end", o_packet_end, e.pe);
        if (o_write_enable) check("data", o_data, e.data);
      end
    end
  end

  task automatic run_packet(input int size, input int mode, input logic [DW-1:0] base);
    exp_t e;
    int   sp, swe, spe, budget, gap, cyc, last_cyc, fin_cyc;
    for (int i = 0; i < size; i++) begin
      buf_q.push_back(base + DW'(i));
      e.zlp  = 1'b0;
      e.pe   = (i == size - 1) && ((size % 256) != 0);
      e.data = base + DW'(i);
      exp_q.push_back(e);
    end
    if (size == 0) begin
      e.zlp = 1'b1; e.pe = 1'b1; e.data = '0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    sp = pop_total; swe = we_total; spe = pe_total;
    i_packet_size     = 24'(size);
    i_out_path_enable = 1'b1;
    if (mode == M_WAITDMA) i_dma_ready = 1'b0;
    budget = size * 4 + 40; gap = 0; cyc = 0; last_cyc = -1; fin_cyc = -1;
    while (!o_out_path_finished && budget > 0) begin
      @(negedge clk);
      budget--; cyc++;
      i_packet_size = 24'd3;
      if (last_cyc < 0 && size > 0 && pop_total - sp == size) last_cyc = cyc;
      case (mode)
        M_DMAGAP: begin
          if (pop_total - sp >= 2 && gap < 3) begin
            i_dma_ready = 1'b0; gap++;
          end else if (gap == 3) begin
            check("dma_gap_pops", pop_total - sp, 2);
            i_dma_ready = 1'b1; gap++;
          end
        end
        M_TOGGLE: buf_gate = ~buf_gate;
        M_DROP:   if (pop_total - sp >= 2) i_out_path_enable = 1'b0;
        M_WAITDMA: begin
          if (cyc == 1) check("wait_dma_busy", o_out_path_busy, 1'b1);
          if (cyc == 3) begin
            check("wait_dma_pops", pop_total - sp, 0);
            i_dma_ready = 1'b1;
          end
        end
        default: ;
      endcase
    end
    fin_cyc = cyc;
    check("finished", o_out_path_finished, 1'b1);
    check("busy_at_finish", o_out_path_busy, 1'b0);
    check("write_count", o_write_count, 24'(size));
    check("pop_total", pop_total - sp, size);
    check("we_total", we_total - swe, size);
    check("pe_total", pe_total - spe, ((size == 0) || (size % 256 != 0)) ? 1 : 0);
    if (size > 0) check("finish_latency", fin_cyc - last_cyc, 1);
    buf_gate    = 1'b1;
    i_dma_ready = 1'b1;
    if (mode != M_DROP) begin
      repeat (2) begin
        @(negedge clk);
        check("finished_hold", o_out_path_finished, 1'b1);
      end
      i_out_path_enable = 1'b0;
    end
    @(negedge clk);
    check("back_to_idle", {o_out_path_finished, o_out_path_busy}, 2'b00);
  endtask

  initial begin
    exp_t e;
    int   budget, spe;
    rst = 1'b1;
    i_out_path_enable = 1'b0;
    i_packet_size = 24'd0;
    i_dma_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we", o_write_enable, 1'b0);
    check("rst_pe", o_packet_end, 1'b0);
    check("rst_data", o_data, '0);
    check("rst_count", o_write_count, 24'd0);
    check("rst_busy_fin", {o_out_path_busy, o_out_path_finished}, 2'b00);
    rst = 1'b0;

    run_packet(4,   M_NORMAL, 32'h0000_00A0);
    run_packet(256, M_NORMAL, 32'h0000_1000);
    run_packet(300, M_NORMAL, 32'h0000_2000);
    run_packet(0,   M_NORMAL, 32'h0);
    run_packet(8,   M_DMAGAP, 32'h0000_3000);
    run_packet(6,   M_TOGGLE, 32'h0000_4000);
    run_packet(5,   M_DROP,   32'h0000_5000);

    // Reset in the middle of a 10-word packet.
    for (int i = 0; i < 10; i++) begin
      buf_q.push_back(32'h7000 + i);
      e.zlp = 1'b0; e.pe = (i == 9); e.data = 32'h7000 + i;
      exp_q.push_back(e);
    end
    @(negedge clk);
    i_packet_size = 24'd10;
    i_out_path_enable = 1'b1;
    budget = 40;
    spe = pe_total;
    while (pop_total < 4 + 256 + 300 + 8 + 6 + 5 + 3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("mid_reset_reached", budget > 0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we_pe", {o_write_enable, o_packet_end}, 2'b00);
    check("mid_rst_data", o_data, '0);
    check("mid_rst_count", o_write_count, 24'd0);
    check("mid_rst_busy_fin", {o_out_path_busy, o_out_path_finished}, 2'b00);
    exp_q.delete();
    buf_q.delete();
    i_out_path_enable = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_no_pktend", pe_total - spe, 0);

    run_packet(2, M_WAITDMA, 32'h0000_6000);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fx3_bus_out_path.md
Name: fx3_bus_out_path

Overview:
- Write-direction counterpart of the FX3 slave-FIFO read path.
- Takes one packet of i_packet_size words from an upstream first-word-fall-through (FWFT) buffer and drives it onto the FX3 GPIF slave-FIFO write interface: write strobe, data and packet-end.
- Honours the FX3 DMA-ready flag and upstream data availability.
- Exposes enable/busy/finished handshaking to the bus master, which sequences it alongside the in path.

Parameters:
- DATA_WIDTH, 32: width of the data word on the FX3 bus and upstream buffer.
- FULL_PACKET_WORDS, 256: FX3 DMA buffer size in words. Must be a power of two. A packet that does not end on a multiple of this is "short" and gets PKTEND.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_out_path_enable  in  1  master request to send one packet; hold high until finished.
- o_out_path_busy  out  1  high from packet start until FINISHED.
- o_out_path_finished  out  1  high in FINISHED state.
- i_packet_size  in  24  packet length in words; sampled at packet start.
- i_dma_ready  in  1  FX3 DMA space-available flag, already synchronised.
- i_buf_ready  in  1  upstream FWFT buffer not empty.
- i_data  in  DATA_WIDTH  upstream head-of-buffer word.
- o_data_read  out  1  upstream pop strobe (combinational).
- o_write_enable  out  1  FX3 SLWR, active-high; pad inversion is external.
- o_packet_end  out  1  FX3 PKTEND, active-high.
- o_data  out  DATA_WIDTH  FX3 data bus.
- o_write_count  out  24  words popped so far in the current packet.

Behaviour:
- Reset: state IDLE. o_write_enable, o_packet_end, o_data, o_write_count and the latched size all 0.
- States: IDLE, WAIT_DMA, WRITE, ZLP, FLUSH, FINISHED.
- IDLE:
  - Count cleared.
  - On i_out_path_enable, latch i_packet_size into r_size.
  - If i_dma_ready: go to WRITE when size != 0, else ZLP.
  - If !i_dma_ready: go to WAIT_DMA.
- WAIT_DMA: wait for i_dma_ready, then go to WRITE or ZLP by r_size.
- WRITE pop rule:
  - o_data_read = (state==WRITE) & i_dma_ready & i_buf_ready.
  - Each pop increments the count.
  - Each pop registers i_data into o_data and asserts o_write_enable the next cycle. Latency from pop to SLWR is 1 cycle.
  - o_write_enable is low on every non-pop cycle; o_data holds its last value.
- Flow control inside WRITE:
  - i_dma_ready or i_buf_ready low: no pop, stay in WRITE.
  - Resume on the first cycle both are high.
  - Word order is always preserved.
- Last word: a pop with count == r_size-1.
  - o_packet_end is registered together with that word's o_write_enable iff r_size[log2(FULL_PACKET_WORDS)-1:0] != 0 (short packet).
  - Next state is FLUSH.
- ZLP:
  - Registers o_packet_end=1 for exactly one cycle with o_write_enable=0.
  - Next state is FLUSH.
- FLUSH: one cycle while the final registered strobe is on the bus, then FINISHED.
- FINISHED: hold until i_out_path_enable is low, then IDLE.
- i_out_path_enable: deassertion before FINISHED is ignored; a started packet always completes.
- Pulse widths: o_packet_end is never asserted for more than one cycle per packet. It never occurs outside the last-write or ZLP cycle.
- o_out_path_busy = state not in {IDLE, FINISHED}.
- o_write_count: 24-bit, never exceeds r_size, no wrap. Cleared in IDLE.
- Mid-packet changes: changes on i_packet_size after latch have no effect.
- Reset mid-packet: next cycle is IDLE with all strobes 0. No PKTEND is emitted.

Test Plan:
- Short packet: size=4, dma/buf ready constant, data A0..A3 -> o_data_read 4 consecutive cycles. o_write_enable 4 cycles lagging by 1 with o_data A0..A3. o_packet_end high only with A3. finished 2 cycles after last pop.
- Full packet: size=256 -> 256 writes, o_packet_end never high. size=300 -> 300 writes, PKTEND with word 300.
- Zero-length packet: size=0 -> single o_packet_end pulse, o_write_enable never high, then FINISHED.
- DMA flow control: size=8, i_dma_ready low for 3 cycles after 2nd pop -> no pops or SLWR during the gap. 8 writes total, data in order, count=8.
- Upstream starve and enable behaviour: size=6, i_buf_ready toggling every cycle -> 6 pops only on ready cycles, PKTEND on the 6th write. Dropping enable mid-packet still completes the packet. FINISHED→IDLE only after enable is low.
- Reset mid-packet: rst asserted after 3 of 10 words -> next cycle IDLE, all outputs 0, no PKTEND. A new size=2 packet then completes normally.
